ingress_credit_injector: RTL and testbench

INGRESS_CREDIT_INJECTOR -- requirements
Module: ingress_credit_injector

---
 rtl/ingress_credit_injector_if.sv | 22 ++
 rtl/ingress_credit_injector.sv | 174 +++++++++++++++++
 tb/tb_ingress_credit_injector.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ingress_credit_injector_if.sv
// Source-side handshake and downstream FIFO push/pop bundle for the ingress credit injector.
interface ingress_credit_injector_if #(
    parameter int NUM_REQS = 4,
    parameter int WIDTH    = 8
) ();
    logic [NUM_REQS-1:0]       src_vld;
    logic [NUM_REQS*WIDTH-1:0] src_data;
    logic [NUM_REQS-1:0]       src_rdy;
    logic [NUM_REQS-1:0]       pop;
    logic [NUM_REQS-1:0]       push;
    logic [NUM_REQS*WIDTH-1:0] flat_data_in;

    modport master (
        output src_vld, src_data, pop,
        input  src_rdy, push, flat_data_in
    );

    modport slave (
        input  src_vld, src_data, pop,
        output src_rdy, push, flat_data_in
    );
endinterface

// File: rtl/ingress_credit_injector.sv
// Per-lane credit-gated packet injector into downstream FIFOs, with a one-shot
// magic-packet tag on the first lane-0 beat after arm.
module ingress_credit_injector #(
    parameter int NUM_REQS = 4,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int CNTWID   = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    ingress_credit_injector_if.slave   bus,
    input  logic                       arm,
    output logic                       start,
    output logic [NUM_REQS*CNTWID-1:0] credits,
    output logic                       credit_err
);

    localparam logic [CNTWID-1:0] DEPTH_C = CNTWID'(DEPTH);
    localparam logic [CNTWID-1:0] ONE_C   = CNTWID'(1);
    localparam logic [CNTWID-1:0] ZERO_C  = CNTWID'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SENT  = 2'd2
    } state_e;

    logic                       run_r;
    logic [CNTWID-1:0]          credit_r     [NUM_REQS];
    logic [CNTWID-1:0]          credit_nxt_s [NUM_REQS];
    logic [NUM_REQS-1:0]        rdy_s;
    logic [NUM_REQS-1:0]        accept_s;
    logic [NUM_REQS-1:0]        pop_s;
    logic [NUM_REQS-1:0]        ovf_s;
    logic                       arm_s;
    logic [NUM_REQS-1:0]        push_r;
    logic [NUM_REQS*WIDTH-1:0]  data_r;
    logic                       start_r;
    logic                       err_r;
    logic                       tag_s;
    logic [NUM_REQS*CNTWID-1:0] credits_s;
    state_e                     state_r;
    state_e                     state_nxt_s;

    // Reset release is taken on the first clock edge; until then no lane accepts or counts pops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // Lane readiness, accept and qualified credit return.
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            rdy_s[i]    = run_r & (credit_r[i] != ZERO_C);
            accept_s[i] = bus.src_vld[i] & rdy_s[i];
            pop_s[i]    = bus.pop[i] & run_r;
        end
        arm_s = arm & run_r;
    end

    // Next credit per lane; a pop at full credit saturates and flags overflow.
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            credit_nxt_s[i] = credit_r[i];
            ovf_s[i]        = pop_s[i] & (credit_r[i] == DEPTH_C);
            case ({accept_s[i], pop_s[i]})
                2'b10: credit_nxt_s[i] = credit_r[i] - ONE_C;
                2'b01: begin
                    if (credit_r[i] == DEPTH_C) begin
                        credit_nxt_s[i] = credit_r[i];
                    end else begin
                        credit_nxt_s[i] = credit_r[i] + ONE_C;
                    end
                end
                default: credit_nxt_s[i] = credit_r[i];
            endcase
        end
    end

    // Credit counters and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                credit_r[i] <= DEPTH_C;
            end
            err_r <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                credit_r[i] <= credit_nxt_s[i];
            end
            err_r <= err_r | (|ovf_s);
        end
    end

    // Registered push/data towards the FIFOs; data holds when a lane does not push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            push_r  <= '0;
            data_r  <= '0;
            start_r <= 1'b0;
        end else begin
            push_r  <= accept_s;
            start_r <= tag_s;
            for (int i = 0; i < NUM_REQS; i++) begin
                if (accept_s[i]) begin
                    data_r[i*WIDTH +: WIDTH] <= bus.src_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Magic-tag FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Magic-tag FSM next state; only lane 0 can consume the arm.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (arm_s && accept_s[0]) begin
                    state_nxt_s = ST_SENT;
                end else if (arm_s) begin
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (accept_s[0]) begin
                    state_nxt_s = ST_SENT;
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            ST_SENT: state_nxt_s = ST_SENT;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Magic-tag FSM output: tag the lane-0 beat being accepted this cycle.
    always_comb begin
        tag_s = 1'b0;
        case (state_r)
            ST_IDLE:  tag_s = accept_s[0] & arm_s;
            ST_ARMED: tag_s = accept_s[0];
            default:  tag_s = 1'b0;
        endcase
    end

    // Lane-ordered packing of the credit counters.
    always_comb begin
        credits_s = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            credits_s[i*CNTWID +: CNTWID] = credit_r[i];
        end
    end

    assign bus.src_rdy      = rdy_s;
    assign bus.push         = push_r;
    assign bus.flat_data_in = data_r;
    assign start            = start_r;
    assign credits          = credits_s;
    assign credit_err       = err_r;

endmodule

// File: tb/tb_ingress_credit_injector.sv
// Directed and randomized bench for ingress_credit_injector against a credit/tag reference model.
module tb_ingress_credit_injector;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int D  = 8;
    localparam int CW = $clog2(D + 1);

    logic clk = 1'b0;
    logic rst;
    logic arm;
    logic start;
    logic credit_err;
    logic [N*CW-1:0] credits;

    ingress_credit_injector_if #(.NUM_REQS(N), .WIDTH(W)) bus ();

    ingress_credit_injector #(.NUM_REQS(N), .WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .arm        (arm),
        .start      (start),
        .credits    (credits),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference model: credit = free FIFO slots, tag is one-shot after arm.
    int           m_credit [N];
    bit           m_err, m_armed, m_done, m_run;
    logic [N-1:0]   e_push;
    logic [N*W-1:0] e_data;
    logic           e_start;

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_credit[i] = D;
        m_err = 0; m_armed = 0; m_done = 0; m_run = 0;
        e_push = '0; e_data = '0; e_start = 1'b0;
    endtask

    function automatic logic [N*CW-1:0] exp_credits();
        logic [N*CW-1:0] r;
        for (int i = 0; i < N; i++) r[i*CW +: CW] = CW'(m_credit[i]);
        return r;
    endfunction

    function automatic logic [N-1:0] exp_rdy();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = m_run && (m_credit[i] > 0);
        return r;
    endfunction

    // Advance one clock and move the model along with it.
    task automatic cycle();
        bit [N-1:0] acc, pp;
        bit tag, arm_q;
        logic [N*W-1:0] dsave;
        dsave = bus.src_data;
        arm_q = m_run && arm;
        for (int i = 0; i < N; i++) begin
            acc[i] = m_run && bus.src_vld[i] && (m_credit[i] > 0);
            pp[i]  = m_run && bus.pop[i];
        end
        tag = acc[0] && !m_done && (m_armed || arm_q);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (pp[i] && m_credit[i] == D) m_err = 1;
            m_credit[i] = m_credit[i] - int'(acc[i]) + int'(pp[i]);
            if (m_credit[i] > D) m_credit[i] = D;
            if (acc[i]) e_data[i*W +: W] = dsave[i*W +: W];
        end
        e_push  = acc;
        e_start = tag;
        if (tag) begin
            m_done = 1; m_armed = 0;
        end else if (!m_done && arm_q) begin
            m_armed = 1;
        end
        m_run = rst;
    endtask

    task automatic clear_inputs();
        bus.src_vld = '0; bus.pop = '0; arm = 1'b0;
        bus.src_data = {$urandom, $urandom};
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        model_reset();
        bus.src_vld = '1; bus.pop = '1; arm = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++; if (bus.push !== 4'h0 || start !== 1'b0) $display("FAIL reset_push_start push=%h start=%b want 0/0", bus.push, start); else pass_cnt++;
        chk_cnt++; if (bus.flat_data_in !== 32'h0) $display("FAIL reset_data got=%h want 0", bus.flat_data_in); else pass_cnt++;
        chk_cnt++; if (credits !== 16'h8888 || credit_err !== 1'b0) $display("FAIL reset_credits got=%h err=%b want 8888/0", credits, credit_err); else pass_cnt++;
        chk_cnt++; if (bus.src_rdy !== 4'h0) $display("FAIL reset_rdy got=%h want 0", bus.src_rdy); else pass_cnt++;
        clear_inputs();
        rst = 1'b1;
        #1;
        chk_cnt++; if (bus.src_rdy !== 4'h0) $display("FAIL release_rdy_before_edge got=%h want 0", bus.src_rdy); else pass_cnt++;
        cycle();
        chk_cnt++; if (bus.src_rdy !== 4'hF) $display("FAIL release_rdy_after_edge got=%h want f", bus.src_rdy); else pass_cnt++;
    endtask

    task automatic test_fill();
        int pulses_early, pulses_total;
        pulses_early = 0; pulses_total = 0;
        bus.src_vld = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            bus.src_data = {$urandom};
            cycle();
            if (bus.push[0] === 1'b1) begin
                pulses_total++;
                if (k <= 8) pulses_early++;
            end
            chk_cnt++; if (credits[CW-1:0] !== CW'(k > 8 ? 0 : 8 - k)) $display("FAIL fill_credit k=%0d got=%0d want=%0d", k, credits[CW-1:0], (k > 8 ? 0 : 8 - k)); else pass_cnt++;
            chk_cnt++; if (bus.flat_data_in[W-1:0] !== e_data[W-1:0]) $display("FAIL fill_data k=%0d got=%h want=%h", k, bus.flat_data_in[W-1:0], e_data[W-1:0]); else pass_cnt++;
        end
        chk_cnt++; if (pulses_early !== 8 || pulses_total !== 8) $display("FAIL fill_pulses early=%0d total=%0d want 8/8", pulses_early, pulses_total); else pass_cnt++;
        chk_cnt++; if (bus.src_rdy[0] !== 1'b0) $display("FAIL fill_rdy0 got=%b want 0", bus.src_rdy[0]); else pass_cnt++;
        clear_inputs();
    endtask

    task automatic test_credit_return();
        int pushes;
        bus.src_vld = 4'b0010;
        repeat (8) cycle();
        chk_cnt++; if (credits[CW +: CW] !== 4'd0 || bus.src_rdy[1] !== 1'b0) $display("FAIL cr_empty credit=%0d rdy=%b want 0/0", credits[CW +: CW], bus.src_rdy[1]); else pass_cnt++;
        bus.pop = 4'b0010;
        cycle();
        bus.pop = 4'b0000;
        chk_cnt++; if (bus.src_rdy[1] !== 1'b1) $display("FAIL cr_rdy_after_pop got=%b want 1", bus.src_rdy[1]); else pass_cnt++;
        pushes = 0;
        repeat (3) begin
            cycle();
            if (bus.push[1] === 1'b1) pushes++;
        end
        chk_cnt++; if (pushes !== 1) $display("FAIL cr_one_push got=%0d want 1", pushes); else pass_cnt++;
        bus.src_vld = 4'b0000;
        bus.pop = 4'b0010;
        repeat (3) cycle();
        bus.pop = 4'b0000;
        chk_cnt++; if (credits[CW +: CW] !== 4'd3) $display("FAIL cr_credit3 got=%0d want 3", credits[CW +: CW]); else pass_cnt++;
        bus.src_vld = 4'b0010; bus.pop = 4'b0010;
        cycle();
        clear_inputs();
        chk_cnt++; if (credits[CW +: CW] !== 4'd3 || bus.push[1] !== 1'b1) $display("FAIL cr_acc_pop credit=%0d push=%b want 3/1", credits[CW +: CW], bus.push[1]); else pass_cnt++;
    endtask

    task automatic test_magic_armed();
        int starts;
        bus.pop = 4'b0001;
        repeat (2) cycle();
        bus.pop = 4'b0000;
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        starts = 0;
        repeat (3) begin
            cycle();
            if (start === 1'b1) starts++;
        end
        chk_cnt++; if (starts !== 0) $display("FAIL magic_idle_start got=%0d want 0", starts); else pass_cnt++;
        bus.src_vld = 4'b0001;
        bus.src_data = 32'h000000A5;
        cycle();
        bus.src_vld = 4'b0000;
        chk_cnt++; if (start !== 1'b1 || bus.push[0] !== 1'b1) $display("FAIL magic_start start=%b push0=%b want 1/1", start, bus.push[0]); else pass_cnt++;
        chk_cnt++; if (bus.flat_data_in[W-1:0] !== 8'hA5) $display("FAIL magic_data got=%h want a5", bus.flat_data_in[W-1:0]); else pass_cnt++;
        cycle();
        chk_cnt++; if (start !== 1'b0) $display("FAIL magic_one_cycle got=%b want 0", start); else pass_cnt++;
        starts = 0;
        for (int k = 0; k < 6; k++) begin
            arm = k[0];
            bus.src_vld = 4'b0001; bus.pop = 4'b0001;
            bus.src_data = {$urandom};
            cycle();
            if (start === 1'b1) starts++;
        end
        clear_inputs();
        chk_cnt++; if (starts !== 0) $display("FAIL magic_sent_rearm got=%0d want 0", starts); else pass_cnt++;
    endtask

    task automatic test_magic_same_cycle();
        apply_reset();
        arm = 1'b1;
        bus.src_vld = 4'b0001;
        bus.src_data = 32'h0000003C;
        cycle();
        clear_inputs();
        chk_cnt++; if (start !== 1'b1 || bus.push[0] !== 1'b1) $display("FAIL same_start start=%b push0=%b want 1/1", start, bus.push[0]); else pass_cnt++;
        chk_cnt++; if (bus.flat_data_in[W-1:0] !== 8'h3C) $display("FAIL same_data got=%h want 3c", bus.flat_data_in[W-1:0]); else pass_cnt++;
    endtask

    task automatic test_overflow();
        bus.pop = 4'b0100;
        cycle();
        bus.pop = 4'b0000;
        chk_cnt++; if (credits[2*CW +: CW] !== 4'd8 || credit_err !== 1'b1) $display("FAIL ovf credit=%0d err=%b want 8/1", credits[2*CW +: CW], credit_err); else pass_cnt++;
        repeat (5) cycle();
        chk_cnt++; if (credit_err !== 1'b1) $display("FAIL ovf_sticky got=%b want 1", credit_err); else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        int starts;
        apply_reset();
        arm = 1'b1;
        cycle();
        arm = 1'b0;
        bus.src_vld = 4'b0010;
        cycle();
        chk_cnt++; if (bus.push[1] !== 1'b1) $display("FAIL mid_inflight got=%b want 1", bus.push[1]); else pass_cnt++;
        rst = 1'b0;
        #1;
        model_reset();
        chk_cnt++; if (bus.push !== 4'h0 || start !== 1'b0) $display("FAIL mid_push push=%h start=%b want 0/0", bus.push, start); else pass_cnt++;
        chk_cnt++; if (credits !== 16'h8888) $display("FAIL mid_credits got=%h want 8888", credits); else pass_cnt++;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cycle();
        bus.src_vld = 4'b0001;
        cycle();
        bus.src_vld = 4'b0000;
        starts = (start === 1'b1) ? 1 : 0;
        chk_cnt++; if (bus.push[0] !== 1'b1) $display("FAIL mid_push0 got=%b want 1", bus.push[0]); else pass_cnt++;
        cycle();
        if (start === 1'b1) starts++;
        chk_cnt++; if (starts !== 0) $display("FAIL mid_no_start got=%0d want 0", starts); else pass_cnt++;
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            bus.src_vld  = 4'($urandom);
            bus.pop      = 4'($urandom & $urandom);
            bus.src_data = {$urandom};
            arm          = ($urandom_range(0, 15) == 0);
            cycle();
            chk_cnt++; if (bus.push !== e_push || start !== e_start) $display("FAIL rnd_push k=%0d push=%h start=%b want %h/%b", k, bus.push, start, e_push, e_start); else pass_cnt++;
            chk_cnt++; if (bus.flat_data_in !== e_data) $display("FAIL rnd_data k=%0d got=%h want=%h", k, bus.flat_data_in, e_data); else pass_cnt++;
            chk_cnt++; if (credits !== exp_credits() || credit_err !== m_err) $display("FAIL rnd_credits k=%0d got=%h err=%b want %h/%b", k, credits, credit_err, exp_credits(), m_err); else pass_cnt++;
            chk_cnt++; if (bus.src_rdy !== exp_rdy()) $display("FAIL rnd_rdy k=%0d got=%h want=%h", k, bus.src_rdy, exp_rdy()); else pass_cnt++;
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_fill();
        test_credit_return();
        test_magic_armed();
        test_magic_same_cycle();
        test_overflow();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
